// File: rtl/core_pkg.sv
// Shared definitions for the RV32 multi-cycle core: opcode constants,
// reset instruction and the fetch FSM state type.
package core_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential pc+4 or branch/jump target, plus the
// word-alignment check on whichever target is selected.
module pc_next
    import core_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        br,
    input  logic        br_taken,
    input  logic [31:0] alu_result,
    output logic [31:0] next_pc,
    output logic        misalign
);

    always_comb begin
        // Bit 0 is always cleared so JALR targets need no separate handling.
        if (br && br_taken) begin
            next_pc = {alu_result[31:1], 1'b0};
        end else begin
            next_pc = pc + 32'd4;
        end
        misalign = next_pc[1];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch / PC stage: owns the PC and instruction register and
// runs a single-outstanding IMEM request with a response timeout.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcW,
    input  logic        imemR,
    input  logic        br,
    input  logic        br_taken,
    input  logic [31:0] alu_result,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic        fetch_stall,
    output logic        misalign_err,
    output logic        imem_timeout
);
    import core_pkg::*;

    localparam int CW = $clog2(TIMEOUT) + 1;

    fetch_state_t   state_reg, state_next;
    logic [31:0]    pc_reg, pc_next;
    logic [31:0]    instr_reg, instr_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           pend_reg, pend_next;
    logic [31:0]    pend_pc_reg, pend_pc_next;
    logic           misalign_reg, misalign_next;
    logic           timeout_reg, timeout_next;

    logic [31:0]    target_pc;
    logic           target_misalign;
    logic           pc_write_ok;
    logic           wait_exit;

    pc_next u_pc_next (
        .pc         (pc_reg),
        .br         (br),
        .br_taken   (br_taken),
        .alu_result (alu_result),
        .next_pc    (target_pc),
        .misalign   (target_misalign)
    );

    assign pc_write_ok = pcW && !target_misalign;
    assign wait_exit   = imem_rvalid || (cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC;
            instr_reg    <= NOP_INSTR;
            cnt_reg      <= '0;
            pend_reg     <= 1'b0;
            pend_pc_reg  <= '0;
            misalign_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            cnt_reg      <= cnt_next;
            pend_reg     <= pend_next;
            pend_pc_reg  <= pend_pc_next;
            misalign_reg <= misalign_next;
            timeout_reg  <= timeout_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        cnt_next      = cnt_reg;
        pend_next     = pend_reg;
        pend_pc_next  = pend_pc_reg;
        misalign_next = misalign_reg | (pcW & target_misalign);
        timeout_next  = timeout_reg;
        imem_req      = 1'b0;

        case (state_reg)
            IDLE: begin
                // The request always carries the pre-update pc.
                if (pc_write_ok) begin
                    pc_next = target_pc;
                end
                if (imemR) begin
                    imem_req   = 1'b1;
                    state_next = WAIT;
                    cnt_next   = '0;
                    pend_next  = 1'b0;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg + CW'(1);
                if (pc_write_ok) begin
                    pend_next    = 1'b1;
                    pend_pc_next = target_pc;
                end
                // pc is frozen while waiting so imem_addr stays stable.
                if (wait_exit) begin
                    state_next = IDLE;
                    pend_next  = 1'b0;
                    if (imem_rvalid) begin
                        instr_next = imem_rdata;
                    end else begin
                        timeout_next = 1'b1;
                    end
                    if (pc_write_ok) begin
                        pc_next = target_pc;
                    end else if (pend_reg) begin
                        pc_next = pend_pc_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign imem_addr    = pc_reg;
    assign pc           = pc_reg;
    assign pc_plus4     = pc_reg + 32'd4;
    assign instr        = instr_reg;
    assign opcode       = instr_reg[6:0];
    assign fetch_stall  = (state_reg == WAIT);
    assign misalign_err = misalign_reg;
    assign imem_timeout = timeout_reg;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and PC stage of the multi-cycle RV32 datapath.
- Sits directly upstream of `control`:
  - holds the PC and issues instruction-memory reads when `control` asserts `imemR`;
  - latches the returned word into the instruction register and drives `opcode` back into `control`.
- Applies `pcW`/`br` from `control` to select the next PC: sequential PC+4, or the branch/jump target computed by the ALU.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles spent waiting for an IMEM response before the request is abandoned.
- NOP_INSTR, 32'h0000_0013, IR value after reset (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pcW  in  1  PC write enable from control.
- imemR  in  1  IMEM read request from control.
- br  in  1  branch/jump select from control.
- br_taken  in  1  branch condition result from ALU compare; 1 for unconditional jumps.
- alu_result  in  32  branch/jump target from the ALU.
- imem_rdata  in  32  instruction word from IMEM.
- imem_rvalid  in  1  IMEM response valid, single-cycle pulse.
- imem_req  out  1  IMEM request pulse, one cycle.
- imem_addr  out  32  IMEM word address (= pc).
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, for link writes.
- instr  out  32  instruction register.
- opcode  out  7  instr[6:0], to control.
- fetch_stall  out  1  high while an IMEM request is outstanding.
- misalign_err  out  1  sticky: a target with bit 1 set was rejected.
- imem_timeout  out  1  sticky: an IMEM response exceeded TIMEOUT cycles.

Behaviour:
- Reset (rst=1 at a clk edge) values:
  - pc=RESET_PC; instr=NOP_INSTR, so opcode=7'b0010011;
  - state=IDLE; imem_req=0; fetch_stall=0;
  - misalign_err=0; imem_timeout=0; pending_pcw=0; wait counter=0.
- Reset mid-request abandons the request; a late imem_rvalid arriving after reset is ignored while in IDLE.
- FSM states: IDLE, WAIT.
- IDLE:
  - imemR=1 → imem_req=1 for exactly one cycle, imem_addr=pc, go to WAIT, counter cleared.
  - imemR=0 → stay in IDLE.
- WAIT:
  - fetch_stall=1 and the counter increments each cycle.
  - imem_rvalid=1 → instr<=imem_rdata (visible the next cycle), go to IDLE.
  - counter reaches TIMEOUT-1 with no rvalid → imem_timeout<=1, instr unchanged, go to IDLE.
  - imemR=1 while in WAIT is ignored; no second outstanding request is ever issued.
- Next-PC selection:
  - br & br_taken → target = {alu_result[31:1],1'b0}; the JALR low-bit clear is always applied.
  - otherwise → target = pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- PC update:
  - pcW=1 in IDLE → pc<=target next cycle.
  - pcW=1 in WAIT → the target is captured and pending_pcw=1. It is applied on the cycle WAIT exits (response or timeout); pc does not change during WAIT, so imem_addr stays stable.
  - pcW and imemR both high in IDLE: the request uses the old pc; the PC update takes effect the same edge. The old-pc request is the defined ordering.
- Alignment check:
  - target[1]=1 → pc not updated, misalign_err<=1.
  - Sticky until rst.
- Errors never block further operation.
- pc_plus4 and opcode are combinational from registered pc/instr.

Decomposition:
- Shared package `core_pkg`:
  - RV32 opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - NOP_INSTR;
  - fetch FSM state enum (`fetch_state_t`).
- Sub-module `pc_next`: combinational target mux plus alignment check. Outputs next_pc and misalign.

Test Plan:
- Reset release:
  - pc=0, opcode=7'b0010011, imem_req=0, fetch_stall=0.
- Basic fetch:
  - imemR=1 at pc=0; imem_rvalid two cycles later with 32'h00500093.
  - Required: imem_req pulses once with imem_addr=0; fetch_stall high for 2 cycles; next cycle instr=32'h00500093, opcode=7'b0010011.
- Sequential PC:
  - pcW=1, br=0 in IDLE → pc=4 next cycle, pc_plus4=8.
- Taken branch:
  - pc=8, br=1, br_taken=1, alu_result=32'h21, pcW=1 → pc=32'h20.
  - Same with br_taken=0 → pc=32'hC.
- Misaligned target:
  - alu_result=32'h22, br=1, br_taken=1, pcW=1 → pc unchanged, misalign_err=1 and stays 1 until rst.
- Pending write and timeout:
  - pcW=1 during WAIT with target 4 and no rvalid for TIMEOUT=16 cycles.
  - Required: imem_timeout=1 at cycle 16; pc=4 on WAIT exit; instr unchanged.
